// File: rtl/seg_scan_ctrl.sv
// Frame scheduler for the serial 7-segment driver: bit-tick strobe, byte stream, tear-free digit commit.
// Define SEG_SCAN_HEX_DECODE_EN to treat written digits as hex nibble + dp instead of raw segment bytes.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 4,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       update_en,
  output logic [7:0] data,
  output logic       frame_done,
  output logic       busy
);

  localparam int PTR_W = $clog2(2 * NUM_DIGITS);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(2 * NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       shadow [NUM_DIGITS];
  logic [7:0]       active [NUM_DIGITS];
  logic             dirty;

  logic       tick, load_tick, boundary, scanning, wr_ok;
  logic [2:0] dig_idx;
  logic [7:0] seg_raw, sel_byte, cur_byte;

`ifdef SEG_SCAN_HEX_DECODE_EN
  function automatic logic [7:0] seg_of(input logic [7:0] v);
    logic [6:0] s;
    case (v[3:0])
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return {v[7], s};
  endfunction
`else
  function automatic logic [7:0] seg_of(input logic [7:0] v);
    return v;
  endfunction
`endif

  assign scanning  = (state == RUN) || (state == DRAIN);
  assign tick      = (state != IDLE) && (div_cnt == DIV_LAST);
  assign load_tick = tick && (bit_cnt == 3'd7);
  assign boundary  = load_tick && scanning && (ptr == PTR_LAST);
  assign wr_ok     = wr_en && (32'(wr_addr) < NUM_DIGITS);
  assign dig_idx   = 3'(ptr >> 1);

  always_comb begin
    seg_raw = 8'h00;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dig_idx == 3'(i)) seg_raw = active[i];
    sel_byte = 8'h01 << dig_idx;
    if (DIG_ACTIVE_LOW) sel_byte = ~sel_byte;
    cur_byte = ptr[0] ? sel_byte : seg_of(seg_raw);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      ptr        <= '0;
      update_en  <= 1'b0;
      data       <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      dirty      <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= 8'h00;
        active[i] <= 8'h00;
      end
    end else begin
      update_en  <= tick;
      frame_done <= boundary;
      // Registered from ptr so the byte at a load tick is still the one being loaded.
      data       <= scanning ? cur_byte : 8'h00;

      if (state == IDLE)          div_cnt <= '0;
      else if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                        div_cnt <= div_cnt + 1'b1;

      if (tick) bit_cnt <= bit_cnt + 3'd1;
      if (load_tick && scanning) ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;

      case (state)
        IDLE: if (en) begin
          state <= RUN;
          busy  <= 1'b1;
          dirty <= 1'b0;
          for (int i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
        end
        RUN:   if (!en) state <= DRAIN;
        DRAIN: if (en) state <= RUN;
               else if (boundary) state <= FLUSH;
        FLUSH: if (load_tick) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (boundary && dirty) begin
        dirty <= 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
      end

      // Placed last so a write coinciding with a commit keeps dirty set.
      if (wr_ok) dirty <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr_en && wr_addr == 3'(i)) shadow[i] <= wr_data;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: two configurations share one stimulus stream, each with its own model.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
  } exp_t;

`ifdef SEG_SCAN_HEX_DECODE_EN
  localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  function automatic logic [7:0] seg_ref(input logic [7:0] v);
    return {v[7], HEX7[v[3:0]]};
  endfunction
`else
  function automatic logic [7:0] seg_ref(input logic [7:0] v);
    return v;
  endfunction
`endif

  function automatic logic [7:0] sel_ref(input int d, input bit low);
    int v;
    v = 2 ** d;
    if (low) v = 255 - v;
    return 8'(v);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int N   = (g == 0) ? 4 : 3;
    localparam int TD  = (g == 0) ? 4 : 2;
    localparam bit DAL = (g == 1);

    logic       upd, fd, bsy;
    logic [7:0] dat;

    seg_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .DIG_ACTIVE_LOW(DAL)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .update_en(upd), .data(dat), .frame_done(fd), .busy(bsy)
    );

    exp_t       q[$];
    logic [7:0] m_shadow [8];
    logic [7:0] m_active [8];
    bit         m_dirty, m_stop, exp_pulse;
    int         phase;  // 0 idle, 1 scanning, 2 flushing
    int         t, kend;

    // Reference: ticks fall every TD clks from the start edge; tick k carries byte (k/8) mod 2N.
    initial begin
      int         k, idx;
      logic [7:0] b;
      bit         last;
      phase = 0; exp_pulse = 0; m_dirty = 0; m_stop = 0; t = 0; kend = 0;
      for (int i = 0; i < 8; i++) begin m_shadow[i] = 8'h00; m_active[i] = 8'h00; end
      forever begin
        @(posedge clk);
        exp_pulse = 0;
        if (!rst_n) begin
          phase = 0; m_dirty = 0; q.delete();
          for (int i = 0; i < 8; i++) begin m_shadow[i] = 8'h00; m_active[i] = 8'h00; end
        end else begin
          if (phase == 0) begin
            if (en) begin
              phase = 1; t = 0; m_stop = 0; m_active = m_shadow; m_dirty = 0;
            end
          end else begin
            t++;
            if (t % TD == 0) begin
              k = t / TD - 1;
              exp_pulse = 1;
              if (phase == 2) begin
                q.push_back('{8'h00, 1'b0});
                if (k == kend) phase = 0;
              end else begin
                idx  = (k / 8) % (2 * N);
                b    = (idx % 2 == 0) ? seg_ref(m_active[idx / 2]) : sel_ref(idx / 2, DAL);
                last = (k % (16 * N)) == (16 * N - 1);
                q.push_back('{b, last});
                if (last) begin
                  if (m_dirty) begin m_active = m_shadow; m_dirty = 0; end
                  if (m_stop && !en) begin phase = 2; kend = k + 8; end
                end
              end
            end
            if (phase == 1) m_stop = !en;
          end
          if (wr_en && wr_addr < N) begin m_shadow[wr_addr] = wr_data; m_dirty = 1; end
        end
      end
    end

    initial begin
      exp_t e;
      @(posedge clk);
      forever begin
        @(negedge clk);
        tests++;
        if (upd !== exp_pulse) begin
          fails++;
          $display("FAIL cfg%0d update_en @%0t: got %b expected %b", g, $time, upd, exp_pulse);
        end
        tests++;
        if (bsy !== (phase != 0)) begin
          fails++;
          $display("FAIL cfg%0d busy @%0t: got %b expected %b", g, $time, bsy, phase != 0);
        end
        tests++;
        if (exp_pulse) begin
          if (q.size() == 0) begin
            fails++;
            $display("FAIL cfg%0d scoreboard @%0t: tick with no expected entry", g, $time);
          end else begin
            e = q.pop_front();
            if (dat !== e.d || fd !== e.f) begin
              fails++;
              $display("FAIL cfg%0d tick_byte @%0t: got data=%h frame_done=%b expected data=%h frame_done=%b",
                       g, $time, dat, fd, e.d, e.f);
            end
          end
        end else if (fd !== 1'b0 || (phase == 0 && dat !== 8'h00)) begin
          fails++;
          $display("FAIL cfg%0d quiet @%0t: got data=%h frame_done=%b expected frame_done=0%s",
                   g, $time, dat, fd, (phase == 0) ? " data=00" : "");
        end
      end
    end
  end

  task automatic run_cycles(input int n, input int wr_odds);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      wr_en   = ($urandom_range(0, wr_odds - 1) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'($urandom);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; wr_addr = 3'd5; en = 1'b1;

    // The edge after this drive starts both scans; edge 768 later is a boundary for both frame lengths.
    for (int c = 0; c < 1100; c++) begin
      @(posedge clk); #1;
      wr_en   = (c + 1 == 768) || ($urandom_range(0, 29) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom);
    end

    en = 1'b0; run_cycles(5, 40);
    en = 1'b1; run_cycles(150, 40);
    en = 1'b0; run_cycles(700, 40);
    en = 1'b1; run_cycles(401, 25);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycles(300, 25);
    en = 1'b0; run_cycles(600, 40);
    wr_en = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
